// File: rtl/interrupt_scheduler_v2.sv
// AXI4-Lite interrupt aggregator: edge-latched PENDING, per-channel ENABLE, fixed or round-robin CLAIM.
// Define INTSCHED_TIMESTAMP_EN to add a cycle counter and a claim timestamp register at offset 0x10.
module interrupt_scheduler_v2 #(
  parameter int unsigned NUM_CH             = 8,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [NUM_CH-1:0]                 irq_in,
  output logic                              irq_out
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] OFF_CTRL  = AW'(32'h00);
  localparam logic [AW-1:0] OFF_EN    = AW'(32'h04);
  localparam logic [AW-1:0] OFF_PEND  = AW'(32'h08);
  localparam logic [AW-1:0] OFF_CLAIM = AW'(32'h0C);
`ifdef INTSCHED_TIMESTAMP_EN
  localparam logic [AW-1:0] OFF_TS    = AW'(32'h10);
`endif

  logic                          awready_q, awready_d;
  logic                          bvalid_q, bvalid_d;
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                    ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]             enable_q, enable_d;
  logic [NUM_CH-1:0]             pending_q, pending_d;
  logic [NUM_CH-1:0]             irq_prev_q;
  logic [4:0]                    rr_ptr_q, rr_ptr_d;
  logic                          irq_out_q, irq_out_d;

  logic                          wr_en, rd_en, claim_take;
  logic [AW-1:0]                 wr_off, rd_off;
  logic [NUM_CH-1:0]             rise, clr, cand;
  logic [2*NUM_CH-1:0]           cand_rot;
  logic [4:0]                    rot_sh;
  int unsigned                   claim_pos;
  logic                          claim_valid;
  logic [4:0]                    claim_id;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  logic                          unused_bits;

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign irq_out       = irq_out_q;

  assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA, S_AXI_WSTRB};

  assign wr_off     = {S_AXI_AWADDR[AW-1:2], 2'b00};
  assign rd_off     = {S_AXI_ARADDR[AW-1:2], 2'b00};
  assign wr_en      = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en      = arready_q & S_AXI_ARVALID;
  assign rise       = irq_in & ~irq_prev_q;
  assign claim_take = rd_en && (rd_off == OFF_CLAIM) && claim_valid;

  // Rotate candidates so the search start (0 or rr_ptr) sits at bit 0, then take the lowest set bit.
  always_comb begin
    cand        = pending_q & enable_q;
    rot_sh      = ctrl_q[1] ? rr_ptr_q : 5'd0;
    cand_rot    = {cand, cand} >> rot_sh;
    claim_valid = 1'b0;
    claim_id    = '0;
    claim_pos   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!claim_valid && cand_rot[k]) begin
        claim_pos = k + 32'(rot_sh);
        if (claim_pos >= NUM_CH) claim_pos = claim_pos - NUM_CH;
        claim_valid = 1'b1;
        claim_id    = 5'(claim_pos);
      end
    end
  end

  always_comb begin
    awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
    arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    bvalid_d  = bvalid_q;
    if (wr_en) bvalid_d = 1'b1;
    else if (S_AXI_BREADY) bvalid_d = 1'b0;
    rvalid_d = rvalid_q;
    if (rd_en) rvalid_d = 1'b1;
    else if (S_AXI_RREADY) rvalid_d = 1'b0;
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    enable_d = enable_q;
    clr      = '0;
    rr_ptr_d = rr_ptr_q;
    if (wr_en && (wr_off == OFF_CTRL) && S_AXI_WSTRB[0]) ctrl_d = S_AXI_WDATA[1:0];
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr_en && (wr_off == OFF_EN) && S_AXI_WSTRB[i/8]) enable_d[i] = S_AXI_WDATA[i];
      if (wr_en && (wr_off == OFF_PEND) && S_AXI_WSTRB[i/8] && S_AXI_WDATA[i]) clr[i] = 1'b1;
      if (claim_take && (claim_id == 5'(i))) clr[i] = 1'b1;
    end
    if (claim_take) begin
      if (32'(claim_id) == NUM_CH - 1) rr_ptr_d = '0;
      else rr_ptr_d = claim_id + 5'd1;
    end
    // A new edge wins over a same-cycle W1C or claim of that channel.
    pending_d = (pending_q & ~clr) | rise;
    irq_out_d = ctrl_q[0] & (|(pending_q & enable_q));
  end

`ifdef INTSCHED_TIMESTAMP_EN
  logic [31:0] tick_q;
  logic [31:0] stamp_q [NUM_CH];
  logic [31:0] ts_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      tick_q <= '0;
      ts_q   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) stamp_q[i] <= '0;
    end else begin
      tick_q <= tick_q + 32'd1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (rise[i] && (!pending_q[i] || clr[i])) stamp_q[i] <= tick_q;
        if (claim_take && (claim_id == 5'(i))) ts_q <= stamp_q[i];
      end
    end
  end
`endif

  always_comb begin
    rd_word = '0;
    case (rd_off)
      OFF_CTRL:  rd_word[1:0] = ctrl_q;
      OFF_EN:    rd_word[NUM_CH-1:0] = enable_q;
      OFF_PEND:  rd_word[NUM_CH-1:0] = pending_q;
      OFF_CLAIM: begin
        rd_word[31]  = claim_valid;
        rd_word[4:0] = claim_id;
      end
`ifdef INTSCHED_TIMESTAMP_EN
      OFF_TS:    rd_word = ts_q;
`endif
      default:   rd_word = '0;
    endcase
    rdata_d = rd_en ? rd_word : rdata_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      ctrl_q     <= '0;
      enable_q   <= '0;
      pending_q  <= '0;
      irq_prev_q <= '0;
      rr_ptr_q   <= '0;
      irq_out_q  <= 1'b0;
    end else begin
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      ctrl_q     <= ctrl_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_in;
      rr_ptr_q   <= rr_ptr_d;
      irq_out_q  <= irq_out_d;
    end
  end

endmodule

// File: tb/tb_interrupt_scheduler_v2.sv
// Scoreboarded bench for interrupt_scheduler_v2: read data checked by a monitor against a queue of model predictions.
module tb_interrupt_scheduler_v2;
  localparam int NUM_CH = 8;
  localparam int AW     = 5;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [AW-1:0]     S_AXI_AWADDR;
  logic              S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID, S_AXI_BREADY;
  logic [AW-1:0]     S_AXI_ARADDR;
  logic              S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID, S_AXI_RREADY;
  logic [NUM_CH-1:0] irq_in;
  logic              irq_out;

  always #5 ACLK = ~ACLK;

  interrupt_scheduler_v2 #(.NUM_CH(NUM_CH), .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .irq_in(irq_in), .irq_out(irq_out)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  logic [1:0]        m_ctrl;
  logic [NUM_CH-1:0] m_en;
  logic [NUM_CH-1:0] m_pend;
  int                m_rr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_irq();
    return m_ctrl[0] && ((m_pend & m_en) != '0);
  endfunction

  function automatic logic [31:0] m_claim();
    logic [NUM_CH-1:0] c;
    c = m_pend & m_en;
    for (int k = 0; k < NUM_CH; k++) begin
      int ch;
      ch = m_ctrl[1] ? (m_rr + k) % NUM_CH : k;
      if (c[ch]) return 32'h8000_0000 | 32'(ch);
    end
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_ctrl = '0;
    m_en   = '0;
    m_pend = '0;
    m_rr   = 0;
  endtask

  // Monitor: every read handshake pops one prediction.
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
        if (exp_q.size() == 0) chk("unexpected_read", 32'(S_AXI_RDATA), 32'hDEAD_BEEF);
        else begin
          chk("rdata", S_AXI_RDATA, exp_q.pop_front());
          chk("rresp", 32'(S_AXI_RRESP), 32'h0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // All tasks start and end at posedge+1.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [NUM_CH-1:0] edge_m, input int bhold);
    logic [31:0] bm;
    int t;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!S_AXI_AWREADY && t < 20);
    chk("awready", 32'(S_AXI_AWREADY), 32'h1);
    chk("wready", 32'(S_AXI_WREADY), 32'h1);
    irq_in = edge_m;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; irq_in = '0;
    bm = '0;
    for (int b = 0; b < 4; b++) if (strb[b]) bm[8*b +: 8] = 8'hFF;
    case (addr)
      5'h00: if (strb[0]) m_ctrl = data[1:0];
      5'h04: m_en = (m_en & ~bm[NUM_CH-1:0]) | (data[NUM_CH-1:0] & bm[NUM_CH-1:0]);
      5'h08: m_pend = m_pend & ~(data[NUM_CH-1:0] & bm[NUM_CH-1:0]);
      default: ;
    endcase
    m_pend = m_pend | edge_m;
    for (int i = 0; i < bhold; i++) begin
      @(negedge ACLK);
      chk("bvalid_hold", 32'(S_AXI_BVALID), 32'h1);
      chk("awready_idle", 32'(S_AXI_AWREADY), 32'h0);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!S_AXI_BVALID && t < 20);
    chk("bvalid", 32'(S_AXI_BVALID), 32'h1);
    chk("bresp", 32'(S_AXI_BRESP), 32'h0);
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    if (bhold > 0) begin
      @(negedge ACLK);
      chk("bvalid_drop", 32'(S_AXI_BVALID), 32'h0);
      @(posedge ACLK); #1;
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp, input int rhold);
    int t;
    exp_q.push_back(exp);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!S_AXI_ARREADY && t < 20);
    chk("arready", 32'(S_AXI_ARREADY), 32'h1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < rhold; i++) begin
      @(negedge ACLK);
      chk("rvalid_hold", 32'(S_AXI_RVALID), 32'h1);
      chk("rdata_hold", S_AXI_RDATA, exp);
      chk("arready_idle", 32'(S_AXI_ARREADY), 32'h0);
      @(posedge ACLK); #1;
    end
    S_AXI_RREADY = 1'b1;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!S_AXI_RVALID && t < 20);
    chk("rvalid", 32'(S_AXI_RVALID), 32'h1);
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    if (rhold > 0) begin
      @(negedge ACLK);
      chk("rvalid_drop", 32'(S_AXI_RVALID), 32'h0);
      @(posedge ACLK); #1;
    end
  endtask

  task automatic do_claim(input int rhold);
    logic [31:0] e;
    int id;
    e = m_claim();
    axi_read(5'h0C, e, rhold);
    if (e[31]) begin
      id = int'(e[4:0]);
      m_pend[id] = 1'b0;
      m_rr = (id + 1) % NUM_CH;
    end
  endtask

  // One-cycle pulse; irq_out must still show the old state one cycle after the edge, the new one two cycles after.
  task automatic pulse(input logic [NUM_CH-1:0] m);
    logic old;
    old = m_irq();
    irq_in = m;
    @(posedge ACLK); #1;
    irq_in = '0;
    m_pend = m_pend | m;
    @(negedge ACLK);
    chk("irq_out_pre", 32'(irq_out), 32'(old));
    @(posedge ACLK);
    @(negedge ACLK);
    chk("irq_out_post", 32'(irq_out), 32'(m_irq()));
    @(posedge ACLK); #1;
  endtask

  task automatic check_irq();
    @(posedge ACLK);
    @(negedge ACLK);
    chk("irq_out", 32'(irq_out), 32'(m_irq()));
    @(posedge ACLK); #1;
  endtask

  initial begin
    int t;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    irq_in = '0;
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'h0);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 32'h0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'h0);
    chk("rst_rvalid", 32'(S_AXI_RVALID), 32'h0);
    chk("rst_rdata", S_AXI_RDATA, 32'h0);
    chk("rst_irq_out", 32'(irq_out), 32'h0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Basic flow on channel 3
    axi_write(5'h04, 32'hFF, 4'hF, '0, 0);
    axi_write(5'h00, 32'h1, 4'hF, '0, 0);
    pulse(8'h08);
    axi_read(5'h08, 32'h08, 0);
    do_claim(0);
    axi_read(5'h08, 32'h00, 0);
    check_irq();

    // Fixed priority
    pulse(8'h24);
    do_claim(0);
    do_claim(0);
    do_claim(0);
    check_irq();

    // Round robin with wrap
    axi_write(5'h00, 32'h3, 4'hF, '0, 0);
    pulse(8'h04);
    do_claim(0);
    pulse(8'h05);
    do_claim(0);
    do_claim(0);
    pulse(8'h04);
    do_claim(0);
    check_irq();

    // Edge beats a same-cycle W1C
    pulse(8'h01);
    axi_write(5'h08, 32'h01, 4'hF, 8'h01, 0);
    axi_read(5'h08, 32'h01, 0);
    axi_write(5'h08, 32'h01, 4'hF, '0, 0);
    axi_read(5'h08, 32'h00, 0);

    // Strobes, ignored writes and unmapped reads
    axi_write(5'h04, 32'h55, 4'h0, '0, 0);
    axi_write(5'h04, 32'h5500, 4'h2, '0, 0);
    axi_read(5'h04, 32'hFF, 0);
    axi_write(5'h04, 32'hFFFF_FFA5, 4'h1, '0, 0);
    axi_read(5'h04, 32'hA5, 0);
    axi_write(5'h00, 32'h0, 4'h0, '0, 0);
    axi_read(5'h00, 32'h3, 0);
    axi_write(5'h0C, 32'hFFFF_FFFF, 4'hF, '0, 0);
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, '0, 0);
    axi_read(5'h10, 32'h0, 0);
    axi_read(5'h14, 32'h0, 0);
    axi_read(5'h1C, 32'h0, 0);
    pulse(8'h02);
    axi_read(5'h08, 32'h02, 0);
    do_claim(0);
    axi_read(5'h08, 32'h02, 0);

    // Backpressure on both response channels
    axi_write(5'h04, 32'hFF, 4'hF, '0, 10);
    axi_read(5'h04, 32'hFF, 10);

    // Randomised traffic against the model
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0, 1: pulse(NUM_CH'($urandom));
        2, 3: do_claim(0);
        4: axi_read(5'h08, 32'(m_pend), 0);
        5: if ($urandom_range(0, 1) == 1) axi_write(5'h00, 32'($urandom_range(0, 3)), 4'hF, '0, 0);
           else axi_write(5'h04, $urandom, 4'hF, '0, 0);
        default: axi_write(5'h08, $urandom, 4'hF, NUM_CH'($urandom), 0);
      endcase
      if (n % 4 == 0) check_irq();
    end

    // Reset in the middle of a read with the response stalled
    axi_write(5'h00, 32'h1, 4'hF, '0, 0);
    axi_write(5'h04, 32'hFF, 4'hF, '0, 0);
    pulse(8'hFF);
    S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!S_AXI_ARREADY && t < 20);
    chk("arready_pre_rst", 32'(S_AXI_ARREADY), 32'h1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    chk("rvalid_pre_rst", 32'(S_AXI_RVALID), 32'h1);
    ARESET = 1'b1;
    #1;
    chk("rvalid_in_rst", 32'(S_AXI_RVALID), 32'h0);
    chk("rdata_in_rst", S_AXI_RDATA, 32'h0);
    chk("irq_out_in_rst", 32'(irq_out), 32'h0);
    model_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      chk("no_resp_after_rst", 32'(S_AXI_RVALID), 32'h0);
    end
    @(posedge ACLK); #1;
    axi_read(5'h00, 32'h0, 0);
    axi_read(5'h04, 32'h0, 0);
    axi_read(5'h08, 32'h0, 0);
    axi_write(5'h00, 32'h3, 4'hF, '0, 0);
    axi_write(5'h04, 32'hFF, 4'hF, '0, 0);
    pulse(8'h81);
    do_claim(0);
    do_claim(0);
    check_irq();

    repeat (4) @(posedge ACLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_scheduler_v2.md
INTERRUPT_SCHEDULER_V2 -- requirements
Module: interrupt_scheduler_v2

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: interrupt channel count, legal range 1..32.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5: AXI4-Lite byte address width.
REQ-003 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width, fixed at 32.
REQ-004 SHALL have port ACLK  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port ARESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR_WIDTH/1/1  write address channel.
REQ-007 SHALL have ports S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
REQ-008 SHALL have ports S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
REQ-009 SHALL have ports S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR_WIDTH/1/1  read address channel.
REQ-010 SHALL have ports S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
REQ-011 SHALL have port irq_in  input  NUM_CH  level sources, synchronous to ACLK.
REQ-012 SHALL have port irq_out  output  1  registered aggregated interrupt request.

Function
REQ-013 SHALL decode registers: 0x00 CTRL (bit0 global enable, bit1 mode: 0 fixed priority, 1 round-robin), 0x04 ENABLE[NUM_CH-1:0], 0x08 PENDING (read status, write-1-to-clear), 0x0C CLAIM (read-only).
REQ-014 SHALL set PENDING[i] on the cycle after a 0->1 edge of irq_in[i], independent of ENABLE.
REQ-015 SHALL accept a write only when AWVALID and WVALID are both high and BVALID is low; AWREADY and WREADY pulse high together for one cycle; BVALID rises the next cycle and holds until BREADY.
REQ-016 SHALL honour WSTRB per byte on CTRL and ENABLE; ignore writes to CLAIM and unmapped offsets.
REQ-017 SHALL accept a read when ARVALID is high and RVALID is low; ARREADY pulses one cycle; RVALID rises the next cycle and holds RDATA stable until RREADY.
REQ-018 SHALL return BRESP and RRESP OKAY (2'b00) always; unmapped reads return 0.
REQ-019 SHALL select, for CLAIM, among PENDING & ENABLE: mode 0 lowest index wins; mode 1 first set index at or above rr_ptr, wrapping from NUM_CH-1 to 0.
REQ-020 SHALL return CLAIM as {bit31 valid, bits4:0 id}; with no candidate return 0x00000000 and change no state.
REQ-021 SHALL, on a valid CLAIM read acceptance, clear PENDING[id] and set rr_ptr to id+1 modulo NUM_CH.
REQ-022 SHALL give set priority over clear: an edge on channel i in the same cycle as a W1C or claim of i leaves PENDING[i] set.
REQ-023 SHALL drive irq_out = CTRL[0] & |(PENDING & ENABLE), registered, one cycle after PENDING changes.
REQ-024 SHALL read PENDING and ENABLE bits at or above NUM_CH as 0.

Reset
REQ-025 SHALL, while ARESET is high, clear CTRL, ENABLE, PENDING, rr_ptr, irq_in edge history, AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA and irq_out to 0 immediately.
REQ-026 SHALL abandon any in-flight AXI transaction on reset, issuing no response after release.

Configuration
REQ-027 SHALL, with INTSCHED_TIMESTAMP_EN defined, add a free-running 32-bit cycle counter wrapping at 0xFFFFFFFF and a register at 0x10 latching the counter value when PENDING of the channel returned by the most recent valid CLAIM was set.
REQ-028 SHALL, without INTSCHED_TIMESTAMP_EN, omit counter and register; offset 0x10 reads 0.

Verification
REQ-029 SHALL cover: write ENABLE=0xFF, CTRL=0x1, pulse irq_in[3] -> PENDING=0x08, irq_out high two cycles after edge, CLAIM reads 0x80000003, then PENDING=0x00, irq_out low.
REQ-030 SHALL cover: mode 0, pending 0x24 -> CLAIMs return 0x80000002, 0x80000005, then 0x00000000.
REQ-031 SHALL cover: mode 1, rr_ptr=3 after claim of 2, pending 0x05 -> CLAIM returns 0x80000000 (wrap), next 0x80000002... after repending ch2.
REQ-032 SHALL cover: W1C 0x01 to PENDING same cycle as irq_in[0] edge -> PENDING[0] stays 1.
REQ-033 SHALL cover: BREADY/RREADY held low 10 cycles -> BVALID/RVALID and RDATA stay stable; ARESET asserted mid-read -> RVALID low at once, all registers 0.
